grid_cursor: RTL and testbench

Parametrised successor to the fixed 6×6 `cursor`. It tracks a one-hot cursor position over a ROWS×COLS card grid and turns up/down/left/right button inputs into moves, with optional wrap-around, hold-to-repeat and skipping of hidden (already matched) cards. It sits between the button front-end and `card_array`. It drives `cur_bus` in the same bit order `card_array` consumes, and reads `hidden_bus` back from it.

---
 rtl/llk_pkg.sv | 31 +++
 rtl/key_repeat.sv | 66 ++++++
 rtl/grid_cursor.sv | 185 ++++++++++++++++++
 tb/tb_grid_cursor.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/llk_pkg.sv
// Shared types and grid constants for the card-game blocks (cursor, card_array, matcher).
package llk_pkg;

    typedef enum logic [2:0] {
        DIR_NONE,
        DIR_UP,
        DIR_DOWN,
        DIR_LEFT,
        DIR_RIGHT
    } dir_t;

    typedef enum logic {
        ST_IDLE,
        ST_SEEK
    } state_t;

    localparam int GRID_ROWS  = 6;
    localparam int GRID_COLS  = 6;
    localparam int GRID_CELLS = GRID_ROWS * GRID_COLS;

    // Fixed button priority: up > down > left > right.
    function automatic dir_t prio_dir(input logic up, input logic down,
                                      input logic left, input logic right);
        if (up)    return DIR_UP;
        if (down)  return DIR_DOWN;
        if (left)  return DIR_LEFT;
        if (right) return DIR_RIGHT;
        return DIR_NONE;
    endfunction

endpackage

// File: rtl/key_repeat.sv
// Turns level button inputs into single-cycle move requests with optional hold-to-repeat.
module key_repeat
    import llk_pkg::*;
#(
    parameter int REPEAT_DELAY  = 0,
    parameter int REPEAT_PERIOD = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic up,
    input  logic down,
    input  logic left,
    input  logic right,
    output logic req,
    output dir_t req_dir
);

    localparam int MAX_CNT = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    dir_t             dir_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rep_q, rep_d;
    dir_t             cur_dir;
    logic             edge_hit, rep_hit;

    // cnt_q counts cycles since the last request; rep_q selects delay vs period threshold.
    always_comb begin
        cur_dir  = prio_dir(up, down, left, right);
        edge_hit = (cur_dir != DIR_NONE) && (cur_dir != dir_q);
        rep_hit  = 1'b0;
        if ((REPEAT_DELAY > 0) && (cur_dir != DIR_NONE) && !edge_hit)
            rep_hit = rep_q ? (cnt_q == CNT_W'(REPEAT_PERIOD))
                            : (cnt_q == CNT_W'(REPEAT_DELAY));
        req     = edge_hit || rep_hit;
        req_dir = cur_dir;

        cnt_d = cnt_q;
        rep_d = rep_q;
        if (cur_dir == DIR_NONE) begin
            cnt_d = '0;
            rep_d = 1'b0;
        end else if (edge_hit) begin
            cnt_d = CNT_W'(1);
            rep_d = 1'b0;
        end else if (rep_hit) begin
            cnt_d = CNT_W'(1);
            rep_d = 1'b1;
        end else if (REPEAT_DELAY > 0) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            dir_q <= DIR_NONE;
            cnt_q <= '0;
            rep_q <= 1'b0;
        end else begin
            dir_q <= cur_dir;
            cnt_q <= cnt_d;
            rep_q <= rep_d;
        end
    end

endmodule

// File: rtl/grid_cursor.sv
// One-hot cursor over a ROWS x COLS card grid with wrap, hold-to-repeat and
// skipping of hidden cards via a small seek FSM.
module grid_cursor
    import llk_pkg::*;
#(
    parameter int ROWS          = GRID_ROWS,
    parameter int COLS          = GRID_COLS,
    parameter int WRAP          = 1,
    parameter int SKIP_HIDDEN   = 1,
    parameter int REPEAT_DELAY  = 0,
    parameter int REPEAT_PERIOD = 4,
    parameter int RST_ROW       = 0,
    parameter int RST_COL       = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     up,
    input  logic                     down,
    input  logic                     left,
    input  logic                     right,
    input  logic [ROWS*COLS-1:0]     hidden_bus,
    output logic [ROWS*COLS-1:0]     cur_bus,
    output logic [$clog2(ROWS)-1:0]  cur_row,
    output logic [$clog2(COLS)-1:0]  cur_col,
    output logic                     busy,
    output logic                     moved
);

    localparam int N  = ROWS * COLS;
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int IW = $clog2(N);

    typedef struct packed {
        logic          blocked;
        logic [RW-1:0] row;
        logic [CW-1:0] col;
    } step_t;

    function automatic logic [IW-1:0] cell_idx(input logic [RW-1:0] r, input logic [CW-1:0] c);
        return IW'(r) * IW'(COLS) + IW'(c);
    endfunction

    function automatic logic [N-1:0] onehot(input logic [IW-1:0] idx);
        logic [N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Edges are compared against ROWS-1/COLS-1 so non-power-of-two grids never overflow.
    function automatic step_t step_cell(input logic [RW-1:0] r, input logic [CW-1:0] c,
                                        input dir_t d);
        step_t s;
        s.blocked = 1'b0;
        s.row     = r;
        s.col     = c;
        case (d)
            DIR_UP: begin
                if (r == '0) begin
                    s.row     = RW'(ROWS - 1);
                    s.blocked = (WRAP == 0);
                end else s.row = r - 1'b1;
            end
            DIR_DOWN: begin
                if (r == RW'(ROWS - 1)) begin
                    s.row     = '0;
                    s.blocked = (WRAP == 0);
                end else s.row = r + 1'b1;
            end
            DIR_LEFT: begin
                if (c == '0) begin
                    s.col     = CW'(COLS - 1);
                    s.blocked = (WRAP == 0);
                end else s.col = c - 1'b1;
            end
            DIR_RIGHT: begin
                if (c == CW'(COLS - 1)) begin
                    s.col     = '0;
                    s.blocked = (WRAP == 0);
                end else s.col = c + 1'b1;
            end
            default: s.blocked = 1'b1;
        endcase
        if (s.blocked) begin
            s.row = r;
            s.col = c;
        end
        return s;
    endfunction

    logic          req;
    dir_t          req_dir;
    state_t        state_q;
    logic [RW-1:0] row_q, cand_row_q;
    logic [CW-1:0] col_q, cand_col_q;
    dir_t          seek_dir_q;
    logic [N-1:0]  cur_bus_q;
    logic          busy_q, moved_q;
    step_t         req_step, cand_step;
    logic          cand_hid, req_hid, next_hid, back_home;

    key_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_key_repeat (
        .clk    (clk),
        .rst    (rst),
        .up     (up),
        .down   (down),
        .left   (left),
        .right  (right),
        .req    (req),
        .req_dir(req_dir)
    );

    // busy looks one cell ahead so it drops in the seek cycle that lands on a visible card.
    always_comb begin
        req_step  = step_cell(row_q, col_q, req_dir);
        cand_step = step_cell(cand_row_q, cand_col_q, seek_dir_q);
        cand_hid  = hidden_bus[cell_idx(cand_row_q, cand_col_q)];
        req_hid   = hidden_bus[cell_idx(req_step.row, req_step.col)];
        next_hid  = hidden_bus[cell_idx(cand_step.row, cand_step.col)];
        back_home = (cand_step.row == row_q) && (cand_step.col == col_q);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            row_q      <= RW'(RST_ROW);
            col_q      <= CW'(RST_COL);
            cur_bus_q  <= onehot(cell_idx(RW'(RST_ROW), CW'(RST_COL)));
            cand_row_q <= '0;
            cand_col_q <= '0;
            seek_dir_q <= DIR_NONE;
            busy_q     <= 1'b0;
            moved_q    <= 1'b0;
        end else begin
            moved_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req && !req_step.blocked) begin
                        if (SKIP_HIDDEN == 0) begin
                            row_q     <= req_step.row;
                            col_q     <= req_step.col;
                            cur_bus_q <= onehot(cell_idx(req_step.row, req_step.col));
                            moved_q   <= 1'b1;
                        end else begin
                            cand_row_q <= req_step.row;
                            cand_col_q <= req_step.col;
                            seek_dir_q <= req_dir;
                            busy_q     <= req_hid;
                            state_q    <= ST_SEEK;
                        end
                    end
                end
                ST_SEEK: begin
                    if (!cand_hid) begin
                        row_q     <= cand_row_q;
                        col_q     <= cand_col_q;
                        cur_bus_q <= onehot(cell_idx(cand_row_q, cand_col_q));
                        moved_q   <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= ST_IDLE;
                    end else if (cand_step.blocked || back_home) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        cand_row_q <= cand_step.row;
                        cand_col_q <= cand_step.col;
                        busy_q     <= next_hid;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cur_bus = cur_bus_q;
    assign cur_row = row_q;
    assign cur_col = col_q;
    assign busy    = busy_q;
    assign moved   = moved_q;

endmodule

// File: tb/tb_grid_cursor.sv
// Bench for grid_cursor: four parameter variants on shared inputs, checked each cycle against a behavioural model.
module tb_grid_cursor;

    localparam int NI = 4;

    logic        clk = 1'b0;
    logic        rst, up, down, left, right;
    logic [35:0] hidden;

    always #5 clk = ~clk;

    // Variant table: 0 wrap+repeat, 1 no-wrap, 2 wrap+skip, 3 3x5 no-wrap skip repeat.
    int p_rows[NI] = '{6, 6, 6, 3};
    int p_cols[NI] = '{6, 6, 6, 5};
    int p_wrap[NI] = '{1, 0, 1, 0};
    int p_skip[NI] = '{0, 0, 1, 1};
    int p_dly [NI] = '{8, 0, 0, 3};
    int p_per [NI] = '{4, 4, 4, 2};
    int p_rr  [NI] = '{0, 0, 0, 1};
    int p_rc  [NI] = '{0, 0, 0, 2};

    logic [35:0] bus_a, bus_b, bus_c;
    logic [14:0] bus_d;
    logic [2:0]  row_a, col_a, row_b, col_b, row_c, col_c, col_d;
    logic [1:0]  row_d;
    logic [3:0]  busy_v, moved_v;

    grid_cursor #(.ROWS(6), .COLS(6), .WRAP(1), .SKIP_HIDDEN(0), .REPEAT_DELAY(8),
                  .REPEAT_PERIOD(4), .RST_ROW(0), .RST_COL(0)) u_a (
        .clk(clk), .rst(rst), .up(up), .down(down), .left(left), .right(right),
        .hidden_bus(hidden), .cur_bus(bus_a), .cur_row(row_a), .cur_col(col_a),
        .busy(busy_v[0]), .moved(moved_v[0]));

    grid_cursor #(.ROWS(6), .COLS(6), .WRAP(0), .SKIP_HIDDEN(0), .REPEAT_DELAY(0),
                  .REPEAT_PERIOD(4), .RST_ROW(0), .RST_COL(0)) u_b (
        .clk(clk), .rst(rst), .up(up), .down(down), .left(left), .right(right),
        .hidden_bus(hidden), .cur_bus(bus_b), .cur_row(row_b), .cur_col(col_b),
        .busy(busy_v[1]), .moved(moved_v[1]));

    grid_cursor #(.ROWS(6), .COLS(6), .WRAP(1), .SKIP_HIDDEN(1), .REPEAT_DELAY(0),
                  .REPEAT_PERIOD(4), .RST_ROW(0), .RST_COL(0)) u_c (
        .clk(clk), .rst(rst), .up(up), .down(down), .left(left), .right(right),
        .hidden_bus(hidden), .cur_bus(bus_c), .cur_row(row_c), .cur_col(col_c),
        .busy(busy_v[2]), .moved(moved_v[2]));

    grid_cursor #(.ROWS(3), .COLS(5), .WRAP(0), .SKIP_HIDDEN(1), .REPEAT_DELAY(3),
                  .REPEAT_PERIOD(2), .RST_ROW(1), .RST_COL(2)) u_d (
        .clk(clk), .rst(rst), .up(up), .down(down), .left(left), .right(right),
        .hidden_bus(hidden[14:0]), .cur_bus(bus_d), .cur_row(row_d), .cur_col(col_d),
        .busy(busy_v[3]), .moved(moved_v[3]));

    logic [35:0] d_bus[NI];
    int          d_row[NI], d_col[NI];

    always_comb begin
        d_bus[0] = bus_a;  d_row[0] = int'(row_a); d_col[0] = int'(col_a);
        d_bus[1] = bus_b;  d_row[1] = int'(row_b); d_col[1] = int'(col_b);
        d_bus[2] = bus_c;  d_row[2] = int'(row_c); d_col[2] = int'(col_c);
        d_bus[3] = {21'b0, bus_d}; d_row[3] = int'(row_d); d_col[3] = int'(col_d);
    end

    // ---------------- behavioural model ----------------
    int m_row[NI], m_col[NI], m_rem[NI], m_trow[NI], m_tcol[NI], m_prev[NI], m_hold[NI];
    bit m_busy[NI], m_moved[NI], m_found[NI];
    int cyc = 0;

    function automatic void nbr(input int i, input int r, input int c, input int d,
                                output int nr, output int nc, output bit blk);
        int R, C;
        R = p_rows[i];
        C = p_cols[i];
        nr = r; nc = c; blk = 1'b0;
        case (d)
            1: begin blk = (p_wrap[i] == 0) && (r == 0);     nr = (r + R - 1) % R; end
            2: begin blk = (p_wrap[i] == 0) && (r == R - 1); nr = (r + 1) % R;     end
            3: begin blk = (p_wrap[i] == 0) && (c == 0);     nc = (c + C - 1) % C; end
            4: begin blk = (p_wrap[i] == 0) && (c == C - 1); nc = (c + 1) % C;     end
            default: blk = 1'b1;
        endcase
        if (blk) begin nr = r; nc = c; end
    endfunction

    function automatic bit is_hidden(input int i, input int r, input int c);
        return hidden[6'(r * p_cols[i] + c)];
    endfunction

    task automatic model_edge(input int i);
        int d, nr, nc, nr2, nc2, k;
        bit blk, req, done;
        if (!rst) begin
            m_row[i] = p_rr[i]; m_col[i] = p_rc[i];
            m_busy[i] = 0; m_moved[i] = 0; m_rem[i] = 0; m_prev[i] = 0; m_hold[i] = 0;
            return;
        end
        d = up ? 1 : down ? 2 : left ? 3 : right ? 4 : 0;
        if (d != 0 && d == m_prev[i]) m_hold[i]++;
        else m_hold[i] = 0;
        m_prev[i] = d;
        req = (d != 0) && (m_hold[i] == 0 || (p_dly[i] > 0 && m_hold[i] >= p_dly[i] &&
              (m_hold[i] - p_dly[i]) % p_per[i] == 0));
        m_moved[i] = 0;
        if (m_rem[i] > 0) begin
            m_rem[i]--;
            if (m_rem[i] == 0) begin
                if (m_found[i]) begin
                    m_row[i] = m_trow[i]; m_col[i] = m_tcol[i]; m_moved[i] = 1;
                end
                m_busy[i] = 0;
            end else m_busy[i] = m_found[i] ? (m_rem[i] > 1) : 1'b1;
        end else if (req) begin
            nbr(i, m_row[i], m_col[i], d, nr, nc, blk);
            if (!blk) begin
                if (p_skip[i] == 0) begin
                    m_row[i] = nr; m_col[i] = nc; m_moved[i] = 1;
                end else begin
                    k = 1; done = 0;
                    while (!done) begin
                        if (!is_hidden(i, nr, nc)) begin
                            m_found[i] = 1; m_trow[i] = nr; m_tcol[i] = nc; done = 1;
                        end else begin
                            nbr(i, nr, nc, d, nr2, nc2, blk);
                            if (blk || (nr2 == m_row[i] && nc2 == m_col[i])) begin
                                m_found[i] = 0; done = 1;
                            end else begin
                                nr = nr2; nc = nc2; k++;
                            end
                        end
                    end
                    m_rem[i]  = k;
                    m_busy[i] = m_found[i] ? (k > 1) : 1'b1;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < NI; i++) model_edge(i);
    end

    // ---------------- compare process ----------------
    int          nvec = 0, nerr = 0;
    bit          chk_en = 0;
    int          lit_seq = 0, lit_done = 0, lit_inst;
    logic [35:0] lit_bus;
    int          lit_row, lit_col;
    bit          lit_busy, lit_moved;

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NI; i++) begin
                logic [35:0] eb;
                eb = 36'h1 << (m_row[i] * p_cols[i] + m_col[i]);
                nvec++;
                if (d_bus[i] !== eb || d_row[i] != m_row[i] || d_col[i] != m_col[i] ||
                    busy_v[i] !== m_busy[i] || moved_v[i] !== m_moved[i]) begin
                    nerr++;
                    $display("FAIL model inst%0d cyc%0d: got bus=%h row=%0d col=%0d busy=%b moved=%b, want bus=%h row=%0d col=%0d busy=%b moved=%b",
                             i, cyc, d_bus[i], d_row[i], d_col[i], busy_v[i], moved_v[i],
                             eb, m_row[i], m_col[i], m_busy[i], m_moved[i]);
                end
            end
        end
        if (lit_seq != lit_done) begin
            lit_done = lit_seq;
            nvec++;
            if (d_bus[lit_inst] !== lit_bus || d_row[lit_inst] != lit_row ||
                d_col[lit_inst] != lit_col || busy_v[lit_inst] !== lit_busy ||
                moved_v[lit_inst] !== lit_moved) begin
                nerr++;
                $display("FAIL literal#%0d inst%0d cyc%0d: got bus=%h row=%0d col=%0d busy=%b moved=%b, want bus=%h row=%0d col=%0d busy=%b moved=%b",
                         lit_seq, lit_inst, cyc, d_bus[lit_inst], d_row[lit_inst], d_col[lit_inst],
                         busy_v[lit_inst], moved_v[lit_inst], lit_bus, lit_row, lit_col,
                         lit_busy, lit_moved);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_lit(input int inst, input logic [35:0] b, input int r, input int c,
                              input bit bz, input bit mv);
        lit_inst = inst; lit_bus = b; lit_row = r; lit_col = c;
        lit_busy = bz; lit_moved = mv;
        lit_seq++;
    endtask

    task automatic set_btn(input logic [3:0] b);
        {up, down, left, right} = b;
    endtask

    task automatic do_reset();
        set_btn(4'b0000);
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
    endtask

    typedef struct packed {
        logic [3:0]  btn;
        logic [7:0]  hold;
        logic [35:0] hid;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs[NV] = '{
        '{4'b0001, 8'd3,  36'h000000000},
        '{4'b1001, 8'd1,  36'h000000000},
        '{4'b0110, 8'd12, 36'h000000000},
        '{4'b0010, 8'd2,  36'h000000C03},
        '{4'b1000, 8'd1,  36'h041041041},
        '{4'b0001, 8'd15, 36'h0000000F0},
        '{4'b0100, 8'd5,  36'hFFFFFFFFF},
        '{4'b0010, 8'd10, 36'h555555555},
        '{4'b0011, 8'd9,  36'h000000060}
    };

    initial begin
        rst = 1'b0;
        hidden = '0;
        set_btn(4'b0000);
        tick(2);
        chk_en = 1;
        rst = 1'b1;
        expect_lit(0, 36'h1, 0, 0, 0, 0);
        tick(1);
        expect_lit(3, 36'h80, 1, 2, 0, 0);

        // wrap without skip: up then left from the origin
        tick(1);
        set_btn(4'b1000); tick(1); set_btn(4'b0000);
        expect_lit(0, 36'h040000000, 5, 0, 0, 1);
        tick(1);
        expect_lit(0, 36'h040000000, 5, 0, 0, 0);
        set_btn(4'b0010); tick(1); set_btn(4'b0000);
        expect_lit(0, 36'h800000000, 5, 5, 0, 1);
        tick(2);

        // blocked edge move then a legal one
        do_reset();
        set_btn(4'b0010); tick(1); set_btn(4'b0000);
        expect_lit(1, 36'h1, 0, 0, 0, 0);
        tick(1);
        expect_lit(1, 36'h1, 0, 0, 0, 0);
        set_btn(4'b0001); tick(1); set_btn(4'b0000);
        expect_lit(1, 36'h2, 0, 1, 0, 1);
        tick(2);

        // skip over two hidden cards
        do_reset();
        hidden = 36'h6;
        set_btn(4'b0001); tick(1); set_btn(4'b0000);
        expect_lit(2, 36'h1, 0, 0, 1, 0);
        tick(1);
        expect_lit(2, 36'h1, 0, 0, 1, 0);
        set_btn(4'b0100);
        tick(1);
        set_btn(4'b0000);
        expect_lit(2, 36'h1, 0, 0, 0, 0);
        tick(1);
        expect_lit(2, 36'h8, 0, 3, 0, 1);
        tick(1);
        expect_lit(2, 36'h8, 0, 3, 0, 0);
        tick(2);

        // failed wrap-around search, then the same cut short by reset
        do_reset();
        hidden = 36'h3E;
        set_btn(4'b0001); tick(1); set_btn(4'b0000);
        expect_lit(2, 36'h1, 0, 0, 1, 0);
        tick(4);
        expect_lit(2, 36'h1, 0, 0, 1, 0);
        tick(1);
        expect_lit(2, 36'h1, 0, 0, 0, 0);
        tick(2);
        do_reset();
        set_btn(4'b0001); tick(1); set_btn(4'b0000);
        tick(1);
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        expect_lit(2, 36'h1, 0, 0, 0, 0);
        tick(3);

        // hold-to-repeat: moves at E0, E8, E12, E16
        do_reset();
        hidden = '0;
        set_btn(4'b0100); tick(1);
        expect_lit(0, 36'h40, 1, 0, 0, 1);
        tick(8);
        expect_lit(0, 36'h1000, 2, 0, 0, 1);
        tick(4);
        expect_lit(0, 36'h40000, 3, 0, 0, 1);
        tick(4);
        expect_lit(0, 36'h1000000, 4, 0, 0, 1);
        tick(3);
        set_btn(4'b0000);
        expect_lit(0, 36'h1000000, 4, 0, 0, 0);
        tick(3);
        expect_lit(0, 36'h1000000, 4, 0, 0, 0);

        // mixed directed vectors, idle gap before each hidden-map change
        for (int v = 0; v < NV; v++) begin
            tick(8);
            hidden = vecs[v].hid;
            set_btn(vecs[v].btn);
            tick(int'(vecs[v].hold));
            set_btn(4'b0000);
        end
        tick(8);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
